// File: rtl/aes_wddl_pkg.sv
// rtl/aes_wddl_pkg.sv - shared types and rail helpers for the WDDL dual-rail datapath
package aes_wddl_pkg;

    localparam int WIDTH_DEF = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        EVAL = 2'd2
    } state_t;

    localparam logic MODE_PRE  = 1'b0;
    localparam logic MODE_EVAL = 1'b1;

    // Precharge: both rails must be 0. Evaluate: exactly one rail must be 1.
    function automatic logic rail_pair_bad(input logic mode, input logic p, input logic n);
        return mode ? ~(p ^ n) : (p | n);
    endfunction

endpackage

// File: rtl/wddl_rail_chk.sv
// rtl/wddl_rail_chk.sv - dual-rail integrity checker for precharge or evaluate phase
module wddl_rail_chk
    import aes_wddl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] n,
    input  logic             mode,
    output logic             viol
);

    logic [WIDTH-1:0] bad;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bad[i] = rail_pair_bad(mode, p[i], n[i]);
    end

    assign viol = |bad;

endmodule

// File: rtl/wddl_xor_seq.sv
// rtl/wddl_xor_seq.sv - precharge/evaluate sequencer for a dual-rail WDDL XOR datapath
module wddl_xor_seq
    import aes_wddl_pkg::*;
#(
    parameter int WIDTH        = WIDTH_DEF,
    parameter int PHASE_CYCLES = 2,
    parameter int DP_LAT       = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_r,
    input  logic [WIDTH-1:0] text_in,
    input  logic [WIDTH-1:0] key_in,
    input  logic             clr_alarm,
    output logic [WIDTH-1:0] d0_p_out,
    output logic [WIDTH-1:0] d0_n_out,
    output logic [WIDTH-1:0] d1_p_out,
    output logic [WIDTH-1:0] d1_n_out,
    input  logic [WIDTH-1:0] res_p_in,
    input  logic [WIDTH-1:0] res_n_in,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] text_out,
    output logic             alarm
);

    // The datapath result must settle inside each phase before it is sampled.
    if (PHASE_CYCLES <= DP_LAT) begin : g_bad_phase
        $error("PHASE_CYCLES must be greater than DP_LAT");
    end

    localparam int             CW   = $clog2(PHASE_CYCLES + 1);
    localparam logic [CW-1:0]  LAST = CW'(PHASE_CYCLES - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] text_r;
    logic [WIDTH-1:0] key_r;
    logic             viol;
    logic             viol_now;
    logic             chk_mode;

    assign chk_mode = (state == EVAL) ? MODE_EVAL : MODE_PRE;

    wddl_rail_chk #(.WIDTH(WIDTH)) u_chk (
        .p    (res_p_in),
        .n    (res_n_in),
        .mode (chk_mode),
        .viol (viol_now)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            text_r   <= '0;
            key_r    <= '0;
            viol     <= 1'b0;
            d0_p_out <= '0;
            d0_n_out <= '0;
            d1_p_out <= '0;
            d1_n_out <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            text_out <= '0;
            alarm    <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (clr_alarm) begin
                alarm <= 1'b0;
            end
            case (state)
                IDLE: begin
                    d0_p_out <= '0;
                    d0_n_out <= '0;
                    d1_p_out <= '0;
                    d1_n_out <= '0;
                    if (ld_r) begin
                        text_r <= text_in;
                        key_r  <= key_in;
                        viol   <= 1'b0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= PRE;
                    end
                end
                PRE: begin
                    if (cnt == LAST) begin
                        viol     <= viol_now;
                        d0_p_out <= text_r;
                        d0_n_out <= ~text_r;
                        d1_p_out <= key_r;
                        d1_n_out <= ~key_r;
                        cnt      <= '0;
                        state    <= EVAL;
                    end else begin
                        d0_p_out <= '0;
                        d0_n_out <= '0;
                        d1_p_out <= '0;
                        d1_n_out <= '0;
                        cnt      <= cnt + CW'(1);
                    end
                end
                EVAL: begin
                    if (cnt == LAST) begin
                        d0_p_out <= '0;
                        d0_n_out <= '0;
                        d1_p_out <= '0;
                        d1_n_out <= '0;
                        cnt      <= '0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= IDLE;
                        // A violation overrides a coincident clr_alarm.
                        if (viol || viol_now) begin
                            err   <= 1'b1;
                            alarm <= 1'b1;
                        end else begin
                            text_out <= res_p_in;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    d0_p_out <= '0;
                    d0_n_out <= '0;
                    d1_p_out <= '0;
                    d1_n_out <= '0;
                    cnt      <= '0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wddl_xor_seq.sv
// tb/tb_wddl_xor_seq.sv - scoreboard bench for wddl_xor_seq with a registered WDDL XOR model
module tb_wddl_xor_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         ld_r;
    logic [W-1:0] text_in;
    logic [W-1:0] key_in;
    logic         clr_alarm;
    logic [W-1:0] d0_p, d0_n, d1_p, d1_n;
    logic [W-1:0] res_p, res_n;
    logic         busy, done, err, alarm;
    logic [W-1:0] text_out;

    logic [W-1:0] dp_p, dp_n;
    logic [W-1:0] p_and = '1, n_and = '1, p_or = '0, n_or = '0;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int exp_done = 0;

    logic [W-1:0] last_out = '0;
    bit           alarm_model = 1'b0;
    logic [W+1:0] exp_q[$];

    always #5 clk = ~clk;

    wddl_xor_seq #(.WIDTH(W), .PHASE_CYCLES(2), .DP_LAT(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .ld_r      (ld_r),
        .text_in   (text_in),
        .key_in    (key_in),
        .clr_alarm (clr_alarm),
        .d0_p_out  (d0_p),
        .d0_n_out  (d0_n),
        .d1_p_out  (d1_p),
        .d1_n_out  (d1_n),
        .res_p_in  (res_p),
        .res_n_in  (res_n),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .text_out  (text_out),
        .alarm     (alarm)
    );

    // Registered WDDL XOR gate array, with fault masks applied on its outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_p <= '0;
            dp_n <= '0;
        end else begin
            dp_p <= (d0_p & d1_n) | (d0_n & d1_p);
            dp_n <= (d0_p & d1_p) | (d0_n & d1_n);
        end
    end
    assign res_p = (dp_p & p_and) | p_or;
    assign res_n = (dp_n & n_and) | n_or;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("rail0_p_and_n", 64'(d0_p & d0_n), 64'h0);
            chk("rail1_p_and_n", 64'(d1_p & d1_n), 64'h0);
            if (done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'(done), 64'h0);
                end else begin
                    logic [W+1:0] e;
                    e = exp_q.pop_front();
                    chk("done_err",      64'(err),      64'(e[W+1]));
                    chk("done_text_out", 64'(text_out), 64'(e[W:1]));
                    chk("done_alarm",    64'(alarm),    64'(e[0]));
                end
            end else begin
                chk("err_outside_done", 64'(err), 64'h0);
            end
        end
    end

    // inj: 0 none, 1 precharge fault on res_n[0], 2 evaluate fault (both rails 0)
    task automatic launch(input logic [W-1:0] t, input logic [W-1:0] k, input int inj,
                          input bit clr_coinc, input bit stray_ld);
        bit           e;
        logic [W-1:0] o;
        e = (inj != 0);
        o = e ? last_out : (t ^ k);
        last_out = o;
        alarm_model = alarm_model | e;
        exp_q.push_back({e, o, alarm_model});
        exp_done++;
        ld_r = 1'b1;
        text_in = t;
        key_in = k;
        @(posedge clk); #1;
        ld_r = 1'b0;
        text_in = W'($urandom);
        key_in = W'($urandom);
        if (inj == 1) n_or = 8'h01;
        chk("pre1_rails", 64'({d0_p, d0_n, d1_p, d1_n}), 64'h0);
        chk("pre1_busy", 64'(busy), 64'h1);
        @(posedge clk); #1;
        if (stray_ld) ld_r = 1'b1;
        chk("pre2_rails", 64'({d0_p, d0_n, d1_p, d1_n}), 64'h0);
        @(posedge clk); #1;
        ld_r = 1'b0;
        n_or = '0;
        chk("eval1_rails", 64'({d0_p, d0_n, d1_p, d1_n}), 64'({t, ~t, k, ~k}));
        if (inj == 2) begin
            p_and = '0;
            n_and = '0;
        end
        @(posedge clk); #1;
        if (clr_coinc) clr_alarm = 1'b1;
        chk("eval2_rails", 64'({d0_p, d0_n, d1_p, d1_n}), 64'({t, ~t, k, ~k}));
        chk("eval2_no_done", 64'(done), 64'h0);
        chk("eval2_busy", 64'(busy), 64'h1);
        @(posedge clk); #1;
        clr_alarm = 1'b0;
        p_and = '1;
        n_and = '1;
        chk("latency_done", 64'(done), 64'h1);
        chk("done_busy", 64'(busy), 64'h0);
        chk("done_rails", 64'({d0_p, d0_n, d1_p, d1_n}), 64'h0);
    endtask

    task automatic pulse_clr();
        clr_alarm = 1'b1;
        @(posedge clk); #1;
        clr_alarm = 1'b0;
        alarm_model = 1'b0;
        chk("clr_alarm", 64'(alarm), 64'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        ld_r = 1'b0;
        text_in = '0;
        key_in = '0;
        clr_alarm = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rails", 64'({d0_p, d0_n, d1_p, d1_n}), 64'h0);
        chk("reset_flags", 64'({busy, done, err, alarm}), 64'h0);
        chk("reset_text_out", 64'(text_out), 64'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_busy", 64'(busy), 64'h0);

        launch(8'h3C, 8'hA5, 0, 1'b0, 1'b0);
        launch(8'hFF, 8'hFF, 0, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("done_count_b2b", 64'(done_cnt), 64'd2);

        launch(8'h01, 8'h00, 1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("alarm_sticky", 64'(alarm), 64'h1);
        end

        launch(W'($urandom), W'($urandom), 2, 1'b0, 1'b0);
        pulse_clr();
        launch(W'($urandom), W'($urandom), 2, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("alarm_set_wins", 64'(alarm), 64'h1);
        pulse_clr();

        // Abort in EVAL with an asynchronous reset
        ld_r = 1'b1;
        text_in = 8'h5A;
        key_in = 8'h0F;
        @(posedge clk); #1;
        ld_r = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_rails", 64'({d0_p, d0_n, d1_p, d1_n}), 64'h0);
        chk("async_rst_flags", 64'({busy, done}), 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        last_out = '0;
        alarm_model = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("no_done_after_abort", 64'(done), 64'h0);
        end
        chk("done_count_abort", 64'(done_cnt), 64'(exp_done));
        launch(8'hC3, 8'h3C, 0, 1'b0, 1'b0);

        for (int n = 0; n < 1000; n++) begin
            int inj;
            inj = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
            launch(W'($urandom), W'($urandom), inj, 1'b0, ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 19) == 0) pulse_clr();
        end

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);
        chk("done_count_final", 64'(done_cnt), 64'(exp_done));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wddl_xor_seq.md
Name: wddl_xor_seq

Overview:
- Precharge/evaluate sequencer for a dual-rail WDDL XOR datapath, e.g. a wddl_xor2 array doing AddRoundKey in the AES core.
- Captures single-rail text and key on a load strobe and drives both operands as dual-rail pairs through one precharge phase (all rails 0) and one evaluate phase (true/complement).
- Checks rail integrity of the datapath result in both phases, then returns the single-rail result with a done pulse and a sticky alarm.

Parameters:
WIDTH, 128, datapath width in bits
PHASE_CYCLES, 2, clock cycles spent in each of the PRE and EVAL phases; must be at least DP_LAT+1
DP_LAT, 1, datapath latency in cycles from rail inputs to rail outputs; elaboration-time check that PHASE_CYCLES > DP_LAT

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
ld_r  input  1  load strobe; accepted only in IDLE
text_in  input  WIDTH  single-rail state operand
key_in  input  WIDTH  single-rail key operand
clr_alarm  input  1  synchronous clear of sticky alarm
d0_p_out  output  WIDTH  operand 0 true rail to datapath
d0_n_out  output  WIDTH  operand 0 false rail to datapath
d1_p_out  output  WIDTH  operand 1 true rail to datapath
d1_n_out  output  WIDTH  operand 1 false rail to datapath
res_p_in  input  WIDTH  datapath result true rail
res_n_in  input  WIDTH  datapath result false rail
busy  output  1  high in PRE and EVAL
done  output  1  one-cycle pulse, result/err valid
err  output  1  qualifies done: 1 = rail violation in this transaction
text_out  output  WIDTH  registered single-rail result
alarm  output  1  sticky rail-violation flag

Behaviour:
- Reset, asynchronous: state IDLE, all rail outputs 0, phase counter 0, op registers 0, text_out 0, busy/done/err/alarm 0.
- All outputs are registered.
- States: IDLE, PRE, EVAL.
- IDLE:
  - rails held 0.
  - When ld_r=1: latch text_in/key_in, clear the per-transaction violation flag, counter := 0, go to PRE.
  - ld_r in the cycle done=1 is accepted, since the block is already in IDLE.
- PRE:
  - all four rail buses 0; counter increments.
  - At the edge ending cycle PHASE_CYCLES: sample res_p_in and res_n_in. Any bit 1 marks a violation.
  - Then d0_p := text reg, d0_n := ~text reg, d1_p := key reg, d1_n := ~key reg; counter := 0; go to EVAL.
- EVAL:
  - rails stable; counter increments.
  - At the edge ending cycle PHASE_CYCLES: violation if (res_p_in ^ res_n_in) != all-ones.
  - Same edge: rails := 0; done := 1; go to IDLE.
  - If no violation in either phase: text_out := res_p_in, err := 0.
  - Otherwise: text_out keeps its old value, err := 1, alarm := 1.
- Latency: ld_r sampled at edge E0 → done high in the cycle after edge E0 + 2*PHASE_CYCLES (edge E4 for the default PHASE_CYCLES=2).
- busy is high from the cycle after E0 up to and including the last EVAL cycle.
- ld_r while busy=1 is ignored; there is no queueing. text_in/key_in changes while busy have no effect.
- done and err are low except in the single done cycle.
- alarm is sticky; cleared only by rst or clr_alarm=1.
  - A violation and clr_alarm in the same cycle: alarm ends at 1 (set wins).
- Reset mid-operation returns to IDLE immediately with rails 0. No done is produced for the aborted transaction.
- The controller never drives p=n=1 on any rail pair. In EVAL, exactly one rail of each pair is high.

Decomposition:
- Package aes_wddl_pkg:
  - state enum {IDLE, PRE, EVAL} (2-bit typedef);
  - WIDTH default constant;
  - function for the rail-complement check.
- One natural sub-module: wddl_rail_chk. It takes WIDTH, p, n and a mode bit (precharge/evaluate) and outputs a violation bit. It is reused by later dual-rail S-box stages.
- The datapath (wddl_xor2 instance) is external. The bench and top level connect it.

Test Plan (WIDTH=8, PHASE_CYCLES=2, DP_LAT=1, bench models a correct registered WDDL XOR):
- Reset, then ld_r with text_in=0x3C, key_in=0xA5 → rails 0 for 2 cycles, then d0_p=0x3C/d0_n=0xC3, d1_p=0xA5/d1_n=0x5A for 2 cycles. done=1, err=0 and text_out=0x99 exactly 4 edges after the load edge; alarm=0.
- Back-to-back: ld_r asserted in the done cycle with 0xFF/0xFF → second done with text_out=0x00. A ld_r pulse while busy is ignored: done count stays 2.
- Injected fault: bench forces res_n_in bit 0 to 1 during PRE (text 0x01, key 0x00) → done=1, err=1, text_out keeps 0x00 from the previous transaction, alarm=1 and stays 1 over 10 idle cycles.
- Evaluate fault: bench forces res_p_in=res_n_in=0x00 in EVAL → err=1, alarm=1. clr_alarm pulse → alarm=0 the next cycle. clr_alarm coincident with a violation → alarm=1.
- Reset asserted asynchronously mid-EVAL → all rails, busy and done 0 without waiting for a clock edge, and no done pulse follows. A new ld_r after release completes normally.
- Rail invariant assertion over random text/key for 1000 transactions: never d*_p&d*_n≠0; in EVAL, d*_p^d*_n=all-ones.
